// File: rtl/rv32m_pkg.sv
// Shared definitions for the iterative M-extension multiply/divide unit.
// Contents: funct3 encodings, FSM state encoding and small decode helpers
// used to classify an operation as divide and to tell which operands are
// interpreted as signed.
package rv32m_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // All divide/remainder encodings have funct3[2] set.
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // MUL is treated as signed x signed; its low word is sign-agnostic.
    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// W-bit adder/subtractor with carry-out, shared by the multiply (add) and
// divide (subtract) iterations.
// Ports: a, b operands; sub selects a-b; sum W-bit result; cout carry out
// (for subtraction cout=1 means a >= b, i.e. no borrow).
module muldiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
    assign sum  = full[W-1:0];
    assign cout = full[W];

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit (radix-2, XLEN iterations).
// Ports:
//   pll_1_200MHz  core clock          system_reset  sync active-high reset
//   flush         kill in-flight op   in_valid/in_ready  request handshake
//   funct3        M-extension op      operand_a/b   rs1/rs2 values
//   out_valid/out_ready  result handshake  result  held result
//   busy          unit not idle
module rv_muldiv_unit
    import rv32m_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            pll_1_200MHz,
    input  logic            system_reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int ITW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q,  state_d;
    logic [2:0]        op_q,     op_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              bzero_q,  bzero_d;
    logic [2*XLEN-1:0] acc_q,    acc_d;
    logic [XLEN-1:0]   mcand_q,  mcand_d;
    logic [ITW-1:0]    iter_q,   iter_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Accumulator layout: multiply keeps {partial product, multiplier};
    // divide keeps {partial remainder, dividend/quotient}.
    logic [XLEN-1:0] acc_hi, acc_lo;
    assign acc_hi = acc_q[2*XLEN-1:XLEN];
    assign acc_lo = acc_q[XLEN-1:0];

    // Shared adder: multiply adds the multiplicand into the high half,
    // divide subtracts the divisor from the shifted partial remainder.
    logic [XLEN:0] add_a, add_b, add_sum;
    logic          add_sub, add_cout;

    always_comb begin
        add_b = {1'b0, mcand_q};
        if (is_div(op_q)) begin
            add_a   = {acc_hi, acc_lo[XLEN-1]};
            add_sub = 1'b1;
        end else begin
            add_a   = {1'b0, acc_hi};
            add_sub = 1'b0;
        end
    end

    muldiv_addsub #(.W(XLEN+1)) u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Request decode.
    logic            in_sa, in_sb, in_bzero, in_ovf;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    assign in_sa    = is_signed_a(funct3) & operand_a[XLEN-1];
    assign in_sb    = is_signed_b(funct3) & operand_b[XLEN-1];
    assign mag_a    = in_sa ? -operand_a : operand_a;
    assign mag_b    = in_sb ? -operand_b : operand_b;
    assign in_bzero = (operand_b == '0);
    assign in_ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (operand_a == MIN_VAL) && (operand_b == '1);
    // funct3[1] separates REM/REMU from DIV/DIVU.
    assign special_res = funct3[1] ? (in_bzero ? operand_a : '0)
                                   : (in_bzero ? '1 : MIN_VAL);

    // Iteration steps.
    logic [2*XLEN-1:0] mul_step, div_step;

    assign mul_step = {(acc_lo[0] ? add_sum : {1'b0, acc_hi}), acc_lo[XLEN-1:1]};
    assign div_step = add_cout ? {add_sum[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1}
                               : {acc_hi[XLEN-2:0], acc_lo[XLEN-1], acc_lo[XLEN-2:0], 1'b0};

    // Sign correction. A zero divisor leaves the all-ones quotient
    // unnegated so signed DIV by zero still yields -1.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quot_fix = ((sign_a_q ^ sign_b_q) && !bzero_q) ? -acc_lo : acc_lo;
    assign rem_fix  = sign_a_q ? -acc_hi : acc_hi;

    always_comb begin
        if (is_div(op_q))
            fix_res = op_q[1] ? rem_fix : quot_fix;
        else if (op_q == F3_MUL)
            fix_res = prod_fix[XLEN-1:0];
        else
            fix_res = prod_fix[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        bzero_d  = bzero_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        iter_d   = iter_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    op_d     = funct3;
                    sign_a_d = in_sa;
                    sign_b_d = in_sb;
                    bzero_d  = in_bzero;
                    acc_d    = {{XLEN{1'b0}}, mag_a};
                    mcand_d  = mag_b;
                    iter_d   = ITW'(XLEN-1);
                    state_d  = S_CALC;
                    if (EARLY_OUT && is_div(funct3) && (in_bzero || in_ovf)) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end
                end
            end
            S_CALC: begin
                acc_d = is_div(op_q) ? div_step : mul_step;
                if (iter_q == '0)
                    state_d = S_FIX;
                else
                    iter_d = iter_q - 1'b1;
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge pll_1_200MHz) begin
        if (system_reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            bzero_q  <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            iter_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            bzero_q  <= bzero_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            iter_q   <= iter_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit: three instances (XLEN=32 with and
// without early-out, XLEN=64 with early-out), directed cases, handshake and
// flush/reset scenarios, and random ops against an arithmetic reference.
module tb_rv_muldiv_unit;
    import rv32m_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, out_ready;
    logic [2:0]  funct3;
    logic [2:0]  iv;
    logic [31:0] a32, b32;
    logic [63:0] a64, b64;

    logic        ir_e, ov_e, bz_e, ir_n, ov_n, bz_n, ir_w, ov_w, bz_w;
    logic [31:0] res_e, res_n;
    logic [63:0] res_w;

    int          sel;
    logic        cur_ov, cur_ir, cur_busy;
    logic [63:0] cur_res;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv_muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) u_eo (
        .pll_1_200MHz(clk), .system_reset(rst), .flush(flush), .in_valid(iv[0]),
        .in_ready(ir_e), .funct3(funct3), .operand_a(a32), .operand_b(b32),
        .out_valid(ov_e), .out_ready(out_ready), .result(res_e), .busy(bz_e));

    rv_muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) u_ne (
        .pll_1_200MHz(clk), .system_reset(rst), .flush(flush), .in_valid(iv[1]),
        .in_ready(ir_n), .funct3(funct3), .operand_a(a32), .operand_b(b32),
        .out_valid(ov_n), .out_ready(out_ready), .result(res_n), .busy(bz_n));

    rv_muldiv_unit #(.XLEN(64), .EARLY_OUT(1'b1)) u_64 (
        .pll_1_200MHz(clk), .system_reset(rst), .flush(flush), .in_valid(iv[2]),
        .in_ready(ir_w), .funct3(funct3), .operand_a(a64), .operand_b(b64),
        .out_valid(ov_w), .out_ready(out_ready), .result(res_w), .busy(bz_w));

    always_comb begin
        cur_ov = ov_w; cur_ir = ir_w; cur_busy = bz_w; cur_res = res_w;
        case (sel)
            0: begin cur_ov = ov_e; cur_ir = ir_e; cur_busy = bz_e; cur_res = {32'b0, res_e}; end
            1: begin cur_ov = ov_n; cur_ir = ir_n; cur_busy = bz_n; cur_res = {32'b0, res_n}; end
            default: ;
        endcase
    end

    // Reference: M-extension semantics with wide arithmetic.
    function automatic logic [63:0] ref_op(input int xl, input logic [2:0] f,
                                           input logic [63:0] ai, input logic [63:0] bi);
        logic [63:0] mask, minv, a, b, r;
        logic [127:0] ua, ub, up;
        logic signed [127:0] sa, sb, p;
        mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
        minv = (xl == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        a = ai & mask;
        b = bi & mask;
        ua = {64'b0, a};
        ub = {64'b0, b};
        sa = (xl == 32) ? {{96{a[31]}}, a[31:0]} : {{64{a[63]}}, a};
        sb = (xl == 32) ? {{96{b[31]}}, b[31:0]} : {{64{b[63]}}, b};
        r = '0;
        case (f)
            F3_MUL:    begin p = sa * sb; r = p[63:0]; end
            F3_MULH:   begin p = sa * sb; up = p; up = up >> xl; r = up[63:0]; end
            F3_MULHSU: begin p = sa * $signed(ub); up = p; up = up >> xl; r = up[63:0]; end
            F3_MULHU:  begin up = ua * ub; up = up >> xl; r = up[63:0]; end
            F3_DIV:    if (b == 0) r = mask;
                       else if (a == minv && b == mask) r = minv;
                       else begin p = sa / sb; r = p[63:0]; end
            F3_REM:    if (b == 0) r = a;
                       else if (a == minv && b == mask) r = 0;
                       else begin p = sa % sb; r = p[63:0]; end
            F3_DIVU:   if (b == 0) r = mask; else begin up = ua / ub; r = up[63:0]; end
            default:   if (b == 0) r = a; else begin up = ua % ub; r = up[63:0]; end
        endcase
        return r & mask;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op on instance s, scramble inputs after the accept edge,
    // and count edges (accept edge = 1) until out_valid.
    task automatic do_op(input int s, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] r, output int lat);
        sel = s; funct3 = f; a32 = a[31:0]; b32 = b[31:0]; a64 = a; b64 = b;
        iv[s] = 1'b1;
        @(posedge clk); #1;
        iv[s] = 1'b0;
        funct3 = 3'($urandom); a32 = $urandom; b32 = $urandom; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
        lat = 1;
        while (!cur_ov && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        r = cur_res;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [2:0]  tf [12] = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU, F3_DIV, F3_REM,
                             F3_DIVU, F3_REMU, F3_DIV, F3_REMU, F3_DIV, F3_REM};
    logic [31:0] ta [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd100,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tbv[12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd2, 32'd2, 32'd16, 32'd7,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] te [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'd2,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    bit          tsp[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};

    initial begin
        logic [63:0] r, r0, a, b, mask, minv;
        logic [2:0]  f;
        int          lat, ok, saw, xl, exp_lat;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; iv = '0; funct3 = '0;
        a32 = '0; b32 = '0; a64 = '0; b64 = '0; sel = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            chk($sformatf("rst_in_ready%0d", s), 64'(cur_ir), 64'd1);
            chk($sformatf("rst_out_valid%0d", s), 64'(cur_ov), 64'd0);
            chk($sformatf("rst_busy%0d", s), 64'(cur_busy), 64'd0);
            chk($sformatf("rst_result%0d", s), cur_res, 64'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases on both XLEN=32 instances.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 12; i++) begin
                do_op(s, tf[i], {32'b0, ta[i]}, {32'b0, tbv[i]}, r, lat);
                chk($sformatf("dir%0d_res%0d", s, i), r, {32'b0, te[i]});
                chk($sformatf("dir%0d_lat%0d", s, i), 64'(lat), (s == 0 && tsp[i]) ? 64'd1 : 64'd34);
                drain();
            end
        end

        // Backpressure: result held, in_ready low, then immediate re-accept.
        do_op(1, F3_MUL, 64'd1234, 64'd5678, r0, lat);
        ok = 1;
        repeat (10) begin
            @(posedge clk); #1;
            if (cur_res !== r0 || cur_ir !== 1'b0 || cur_ov !== 1'b1) ok = 0;
        end
        chk("bp_hold", 64'(ok), 64'd1);
        chk("bp_res", r0, 64'd7006652);
        drain();
        chk("bp_idle_ready", 64'(cur_ir), 64'd1);
        chk("bp_idle_busy", 64'(cur_busy), 64'd0);
        do_op(1, F3_DIVU, 64'd1000, 64'd7, r, lat);
        chk("bp_next_lat", 64'(lat), 64'd34);
        chk("bp_next_res", r, 64'd142);
        drain();

        // in_valid during CALC is ignored.
        sel = 1; funct3 = F3_REM; a32 = 32'd100; b32 = 32'd9; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        funct3 = F3_MUL; a32 = 32'd3; b32 = 32'd3; iv[1] = 1'b1;
        ok = 1;
        repeat (3) begin
            if (cur_ir !== 1'b0) ok = 0;
            @(posedge clk); #1;
        end
        iv[1] = 1'b0;
        chk("calc_in_ready", 64'(ok), 64'd1);
        lat = 0;
        while (!cur_ov && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("calc_ignore_res", cur_res, 64'd1);
        r0 = cur_res;
        drain();

        // Flush at iteration 10 of a DIV.
        funct3 = F3_DIV; a32 = 32'hFFFF_FF00; b32 = 32'd3; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 64'(cur_busy), 64'd0);
        chk("flush_ready", 64'(cur_ir), 64'd1);
        chk("flush_res", cur_res, r0);
        saw = 0;
        repeat (40) begin @(posedge clk); #1; if (cur_ov) saw = 1; end
        chk("flush_no_valid", 64'(saw), 64'd0);

        // Flush together with in_valid in IDLE: not accepted.
        iv[1] = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0; flush = 1'b0;
        chk("flush_accept", 64'(cur_busy), 64'd0);

        // Flush in DONE discards the result but keeps result stable.
        do_op(0, F3_DIV, 64'd5, 64'd0, r, lat);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done_valid", 64'(cur_ov), 64'd0);
        chk("flush_done_res", cur_res, 64'hFFFF_FFFF);

        // Reset mid-CALC on the 64-bit instance.
        sel = 2; funct3 = F3_MULHU; a64 = '1; b64 = '1; iv[2] = 1'b1;
        @(posedge clk); #1;
        iv[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", 64'(cur_ir), 64'd1);
        chk("midrst_valid", 64'(cur_ov), 64'd0);
        chk("midrst_busy", 64'(cur_busy), 64'd0);
        chk("midrst_res", cur_res, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Random regressions: XLEN=32 without early-out, XLEN=64 with it.
        for (int k = 0; k < 50; k++) begin
            int s;
            int mode;
            s    = (k < 15) ? 1 : 2;
            xl   = (s == 2) ? 64 : 32;
            mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
            minv = (xl == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
            f    = 3'($urandom_range(0, 7));
            a    = {$urandom, $urandom} & mask;
            b    = {$urandom, $urandom} & mask;
            mode = $urandom_range(0, 7);
            if (mode == 0) b = 0;
            else if (mode == 1) begin a = minv; b = mask; end
            else if (mode == 2) b = 64'($urandom_range(1, 20));
            exp_lat = xl + 2;
            if (s == 2 && f[2] && (b == 0 || ((f == F3_DIV || f == F3_REM) && a == minv && b == mask)))
                exp_lat = 1;
            do_op(s, f, a, b, r, lat);
            chk($sformatf("rnd%0d_f%0d_res", k, f), r, ref_op(xl, f, a, b));
            chk($sformatf("rnd%0d_lat", k), 64'(lat), 64'(exp_lat));
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Parametrised, iterative RV32M/RV64M multiply/divide unit.
- Sits beside the single-cycle ALU in the execute stage.
- Accepts one operation per valid/ready handshake, computes a radix-2 result over XLEN iterations, and holds the result until the consumer accepts it.
- Implements all eight M-extension operations, selected by funct3, including the architected divide-by-zero and overflow results.

Parameters:
- XLEN, 32, operand and result width; legal values are 32 and 64.
- EARLY_OUT, 1, when 1, divide-by-zero and signed overflow complete without iterating.

Ports:
- pll_1_200MHz  input  1  core clock, rising edge
- system_reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of any in-flight operation
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request (IDLE only)
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a  input  XLEN  rs1 value
- operand_b  input  XLEN  rs2 value
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  XLEN  operation result
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: single clock pll_1_200MHz; system_reset is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, result=0.
- Precedence on each edge: system_reset > flush > everything else.
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch funct3;
  - latch the signs of a and b, and the magnitudes of a and b (signed ops only; MULHSU treats b as unsigned);
  - clear the accumulator and load iter_cnt=XLEN-1;
  - go to CALC.
- EARLY_OUT=1 shortcut: if the accepted op is DIV/DIVU/REM/REMU and operand_b==0, or it is DIV/REM with a==MIN and b==-1, compute the special result and go directly to DONE. out_valid is then high the cycle after the accept.
- CALC, multiply: one shift-add step per cycle on a 2*XLEN product register.
- CALC, divide: one restoring step per cycle, using an XLEN+1-bit subtract on the partial remainder.
- CALC exit: when iter_cnt==0, go to FIX; otherwise decrement iter_cnt.
- FIX: apply sign correction.
  - Product is negated if the latched signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Select the low word (MUL) or high word (MULH/MULHSU/MULHU), register it into result, and go to DONE.
- DONE: out_valid=1 and result is held stable. On out_ready, go to IDLE. in_ready stays 0 throughout DONE, so there is no accept on the same edge as the output handshake.
- Latency: accept edge to out_valid = XLEN+2 edges (34 for XLEN=32). Early-out latency is 1 edge.
- Throughput: one op per XLEN+3 cycles minimum.
- Special results (required even when EARLY_OUT=0; in that case they come out of the normal datapath at normal latency):
  - DIV/DIVU with b=0 give all ones.
  - REM/REMU with b=0 give a.
  - DIV with MIN/-1 gives MIN; REM with MIN/-1 gives 0.
- Inputs are sampled only on the accept edge. Changes to operand_a, operand_b or funct3 afterwards have no effect.
- flush in any state: go to IDLE next edge, out_valid=0, result unchanged. flush during DONE discards the result.
- flush coincident with in_valid in IDLE: the request is not accepted.
- out_ready while not in DONE is ignored.

Decomposition:
- Shared package rv32m_pkg:
  - funct3 localparams: F3_MUL through F3_REMU;
  - state encoding: IDLE, CALC, FIX, DONE;
  - the helper predicates is_div(funct3) and is_signed_a/b(funct3).
- One sub-module, muldiv_addsub: an XLEN+1-bit add/subtract with carry-out, instantiated once and shared by the multiply and divide iterations.

Test Plan:
- XLEN=32, MUL a=7, b=-3 -> result 0xFFFFFFEB; out_valid exactly 34 cycles after accept.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFFF/16 -> 0x0FFFFFFF. REMU 100/7 -> 2.
- EARLY_OUT=1: DIV a=5, b=0 -> 0xFFFFFFFF after 1 cycle; REMU a=5, b=0 -> 5; DIV 0x80000000/-1 -> 0x80000000 with REM -> 0. Repeat with EARLY_OUT=0 -> same values at 34 cycles.
- Backpressure and handshake:
  - hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0;
  - raise out_ready -> IDLE next edge, a new request is accepted the following cycle;
  - in_valid during CALC is ignored.
- flush at iteration 10 of a DIV -> IDLE next edge, no out_valid. system_reset asserted mid-CALC -> all outputs at reset values on the next edge. XLEN=64 random regression against a reference model.
